// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle MIPS control unit: opcode and funct
//   encodings, ALU-op and ALU-control codes, the FSM state encoding, the packed
//   control word, and helper functions for next-state and per-state decode.
//
//   Optional feature macro: MULTICYCLE_CTRL_BNE_EN adds the bne opcode, the
//   BNEEX state and the bne control bit.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;

    // Opcode field encodings (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    // Funct field encodings for R-type (instr[5:0])
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes seen by the datapath ALU
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MULTICYCLE_CTRL_BNE_EN
        ,
        BNEEX   = 4'd12
`endif
    } state_t;

    // Everything the FSM drives, bundled so it can be registered as one word.
    // pcwrite/branch/bne are internal; they fold into pcen in the top.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
`ifdef MULTICYCLE_CTRL_BNE_EN
        logic       bne;
`endif
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // True for every encoding the FSM can legitimately occupy.
    function automatic logic state_legal(input state_t s);
        logic ok;
        case (s)
            FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
            RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX: ok = 1'b1;
`ifdef MULTICYCLE_CTRL_BNE_EN
            BNEEX:                                         ok = 1'b1;
`endif
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Transition function; anything unexpected falls back to FETCH.
    function automatic state_t next_state(input state_t s, input logic [OP_W-1:0] op);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:   n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_RTYPE:     n = RTYPEEX;
                    OP_BEQ:       n = BEQEX;
                    OP_ADDI:      n = ADDIEX;
                    OP_J:         n = JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       n = BNEEX;
`endif
                    default:      n = FETCH;
                endcase
            end
            MEMADR:  n = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   n = MEMWB;
            RTYPEEX: n = RTYPEWB;
            ADDIEX:  n = ADDIWB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Moore decode: control word for a given state. Illegal encodings give
    // an all-zero word, so no enable can fire while in them.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
            end
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.iord = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
                c.pcsrc   = 2'b01;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
            end
            JEX: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            BNEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.bne     = 1'b1;
                c.pcsrc   = 2'b01;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational ALU decoder: maps the FSM's ALU-op class plus the R-type
//   funct field onto the 3-bit ALU control code.
//
//   Ports:
//     aluop      in  2        add / sub / use-funct class from the FSM
//     funct      in  FUNCT_W  instr[5:0]
//     alucontrol out 3        ALU operation select
// -----------------------------------------------------------------------------
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alucontrol
);

    // Add is the safe fallback for both an unused aluop code and any funct
    // value outside the supported R-type subset.
    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUCTL_ADD;
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
            default: alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. Walks fetch / decode /
//   execute / memory / writeback one state per clock and drives every mux
//   select and register enable in the datapath.
//
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     op, funct    instruction fields from the instruction register
//     zero         ALU-result-is-zero flag
//     pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//     alusrca, alusrcb, pcsrc, alucontrol   datapath controls
//
//   Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds bne / BNEEX).
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol
);

    state_t state;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;

    // State register and registered control word. The control word is
    // loaded with the decode of the state being entered, so it always equals
    // decode_state(state) and the outputs stay Moore while coming straight
    // from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            ctrl_q <= decode_state(FETCH);
        end else begin
            state  <= next_state(state, op);
            ctrl_q <= decode_state(next_state(state, op));
        end
    end

    // Reset must kill writes in the very cycle it is raised (so an in-flight
    // lw cannot write back), so it overrides the registered word
    // combinationally with the FETCH selects and all enables low. A corrupted
    // state encoding likewise silences every enable until FETCH is re-entered.
    always_comb begin
        ctrl = ctrl_q;
        if (reset) begin
            ctrl          = decode_state(FETCH);
            ctrl.pcwrite  = 1'b0;
            ctrl.irwrite  = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.regwrite = 1'b0;
            ctrl.branch   = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
            ctrl.bne      = 1'b0;
`endif
        end else if (!state_legal(state)) begin
            ctrl = '0;
        end
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign pcen = ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.bne & ~zero);
`else
    assign pcen = ctrl.pcwrite | (ctrl.branch & zero);
`endif

    assign iord     = ctrl.iord;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. Every cycle the stimulus process
//   drives inputs and queues the hand-written expected control vector (with a
//   care mask); the monitor pops one entry per cycle and compares.
//
//   Vector layout (15 bits, MSB first):
//     pcen iord memwrite irwrite regdst memtoreg regwrite alusrca
//     alusrcb[1:0] pcsrc[1:0] alucontrol[2:0]
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    typedef struct {
        string       name;
        logic [14:0] v;
        logic [14:0] m;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    // Hand-derived expected vectors and care masks per state.
    localparam logic [14:0] V_RESET   = 15'b0_0_0_0_0_0_0_0_01_00_010;
    localparam logic [14:0] V_FETCH   = 15'b1_0_0_1_0_0_0_0_01_00_010;
    localparam logic [14:0] M_FULL    = 15'b1_1_1_1_0_0_1_1_11_11_111;
    localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [14:0] M_ALU     = 15'b1_1_1_1_0_0_1_1_11_00_111;
    localparam logic [14:0] V_MEMRD   = 15'b0_1_0_0_0_0_0_0_00_00_000;
    localparam logic [14:0] V_MEMWR   = 15'b0_1_1_0_0_0_0_0_00_00_000;
    localparam logic [14:0] M_MEM     = 15'b1_1_1_1_0_0_1_0_00_00_000;
    localparam logic [14:0] V_MEMWB   = 15'b0_0_0_0_0_1_1_0_00_00_000;
    localparam logic [14:0] V_RTYPEWB = 15'b0_0_0_0_1_0_1_0_00_00_000;
    localparam logic [14:0] V_ADDIWB  = 15'b0_0_0_0_0_0_1_0_00_00_000;
    localparam logic [14:0] M_WB      = 15'b1_1_1_1_1_1_1_0_00_00_000;
    localparam logic [14:0] V_RTYPEEX = 15'b0_0_0_0_0_0_0_1_00_00_000;
    localparam logic [14:0] V_BRNOPC  = 15'b0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] V_BRPC    = 15'b1_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] V_JEX     = 15'b1_0_0_0_0_0_0_0_00_10_000;
    localparam logic [14:0] M_J       = 15'b1_1_1_1_0_0_1_0_00_11_000;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge and queues what
    // the outputs must look like for that cycle.
    task automatic applyStimulus(input logic rst, input logic [5:0] op_i,
                                 input logic [5:0] funct_i, input logic zero_i,
                                 input string name, input logic [14:0] v,
                                 input logic [14:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        op    = op_i;
        funct = funct_i;
        zero  = zero_i;
        e.name = name;
        e.v    = v;
        e.m    = m;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input logic [5:0] op_i,
                        input logic [5:0] funct_i, input logic zero_i,
                        input logic [14:0] v, input logic [14:0] m);
        applyStimulus(1'b0, op_i, funct_i, zero_i, name, v, m);
    endtask

    task automatic checkOutput(input exp_t e, input logic [14:0] act);
        check_count++;
        if (((act ^ e.v) & e.m) == 15'd0) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %015b expected %015b (care %015b)",
                     e.name, act, e.v, e.m);
        end
    endtask

    // Monitor: one comparison per cycle, sampled mid-cycle on the falling edge.
    initial begin : monitor
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, alusrcb, pcsrc, alucontrol};
                checkOutput(e, act);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;

        applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0, "reset0", V_RESET, M_FULL);
        applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0, "reset1", V_RESET, M_FULL);

        // lw: 5 cycles, writeback only in the last
        step("lw_fetch",  6'b100011, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("lw_decode", 6'b100011, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("lw_memadr", 6'b100011, 6'b000000, 1'b0, V_MEMADR, M_ALU);
        step("lw_memrd",  6'b100011, 6'b000000, 1'b0, V_MEMRD,  M_MEM);
        step("lw_memwb",  6'b100011, 6'b000000, 1'b0, V_MEMWB,  M_WB);

        // R-type: slt, and, unknown funct
        step("slt_fetch",  6'b000000, 6'b101010, 1'b0, V_FETCH,  M_FULL);
        step("slt_decode", 6'b000000, 6'b101010, 1'b0, V_DECODE, M_ALU);
        step("slt_ex",     6'b000000, 6'b101010, 1'b0, V_RTYPEEX | 15'd7, M_ALU);
        step("slt_wb",     6'b000000, 6'b101010, 1'b0, V_RTYPEWB, M_WB);
        step("and_fetch",  6'b000000, 6'b100100, 1'b0, V_FETCH,  M_FULL);
        step("and_decode", 6'b000000, 6'b100100, 1'b0, V_DECODE, M_ALU);
        step("and_ex",     6'b000000, 6'b100100, 1'b0, V_RTYPEEX | 15'd0, M_ALU);
        step("and_wb",     6'b000000, 6'b100100, 1'b0, V_RTYPEWB, M_WB);
        step("unk_f_fetch",  6'b000000, 6'b111111, 1'b0, V_FETCH,  M_FULL);
        step("unk_f_decode", 6'b000000, 6'b111111, 1'b0, V_DECODE, M_ALU);
        step("unk_f_ex",     6'b000000, 6'b111111, 1'b0, V_RTYPEEX | 15'd2, M_ALU);
        step("unk_f_wb",     6'b000000, 6'b111111, 1'b0, V_RTYPEWB, M_WB);

        // beq taken and not taken
        step("beq1_fetch",  6'b000100, 6'b000000, 1'b1, V_FETCH,  M_FULL);
        step("beq1_decode", 6'b000100, 6'b000000, 1'b1, V_DECODE, M_ALU);
        step("beq1_ex",     6'b000100, 6'b000000, 1'b1, V_BRPC,   M_FULL);
        step("beq0_fetch",  6'b000100, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("beq0_decode", 6'b000100, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("beq0_ex",     6'b000100, 6'b000000, 1'b0, V_BRNOPC, M_FULL);

        // sw: single memwrite cycle, no regwrite
        step("sw_fetch",  6'b101011, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("sw_decode", 6'b101011, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("sw_memadr", 6'b101011, 6'b000000, 1'b0, V_MEMADR, M_ALU);
        step("sw_memwr",  6'b101011, 6'b000000, 1'b0, V_MEMWR,  M_MEM);

        // addi
        step("addi_fetch",  6'b001000, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("addi_decode", 6'b001000, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("addi_ex",     6'b001000, 6'b000000, 1'b0, V_MEMADR, M_ALU);
        step("addi_wb",     6'b001000, 6'b000000, 1'b0, V_ADDIWB, M_WB);

        // j
        step("j_fetch",  6'b000010, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("j_decode", 6'b000010, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("j_ex",     6'b000010, 6'b000000, 1'b0, V_JEX,    M_J);

        // unknown op: straight back to FETCH
        step("unk_fetch",  6'b111111, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("unk_decode", 6'b111111, 6'b000000, 1'b0, V_DECODE, M_ALU);

        // bne op with zero = 0
        step("bne_fetch",  6'b000101, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("bne_decode", 6'b000101, 6'b000000, 1'b0, V_DECODE, M_ALU);
`ifdef MULTICYCLE_CTRL_BNE_EN
        step("bne_ex",     6'b000101, 6'b000000, 1'b0, V_BRPC,   M_FULL);
`endif

        // reset in the MEMRD cycle of lw: no writeback, restart in FETCH
        step("rlw_fetch",  6'b100011, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("rlw_decode", 6'b100011, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("rlw_memadr", 6'b100011, 6'b000000, 1'b0, V_MEMADR, M_ALU);
        applyStimulus(1'b1, 6'b100011, 6'b000000, 1'b0, "rlw_reset", V_RESET, M_FULL);
        step("rlw_refetch", 6'b111111, 6'b000000, 1'b0, V_FETCH,  M_FULL);
        step("rlw_redecode", 6'b111111, 6'b000000, 1'b0, V_DECODE, M_ALU);
        step("rlw_back",   6'b111111, 6'b000000, 1'b0, V_FETCH,  M_FULL);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            check_count++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
